// File: rtl/myproject_sdiv_36s_9s_33_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per cycle, then sign fix.
// Optional remainder output enabled by defining MYPROJECT_SDIV_REM_EN.
module myproject_sdiv_36s_9s_33_seq #(
  parameter int din0_WIDTH = 36,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 33
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] dout,
`ifdef MYPROJECT_SDIV_REM_EN
  output logic [din1_WIDTH-1:0] rem,
`endif
  output logic                  div_by_zero
);

  localparam int CW = $clog2(din0_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [din0_WIDTH-1:0]   quo_q, quo_d;    // dividend bits shift out of the top, quotient bits shift in
  logic [din1_WIDTH-1:0]   prem_q, prem_d;
  logic [din1_WIDTH-1:0]   dvs_q, dvs_d;
  logic                    qneg_q, qneg_d;
  logic                    aneg_q, aneg_d;
  logic                    zero_q, zero_d;
  logic [dout_WIDTH-1:0]   res_quo_q, res_quo_d;
  logic                    res_dbz_q, res_dbz_d;
  logic                    done_q, done_d;
  logic [dout_WIDTH-1:0]   dout_q, dout_d;
  logic                    dbz_q, dbz_d;
`ifdef MYPROJECT_SDIV_REM_EN
  logic [din1_WIDTH-1:0]   res_rem_q, res_rem_d;
  logic [din1_WIDTH-1:0]   rem_q, rem_d;
`endif

  logic [din1_WIDTH:0]     shifted;
  logic [din1_WIDTH:0]     diff;
  logic                    fits;
  logic [din0_WIDTH-1:0]   quo_full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    prem_d    = prem_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    aneg_d    = aneg_q;
    zero_d    = zero_q;
    res_quo_d = res_quo_q;
    res_dbz_d = res_dbz_q;
    done_d    = 1'b0;
    dout_d    = dout_q;
    dbz_d     = dbz_q;
`ifdef MYPROJECT_SDIV_REM_EN
    res_rem_d = res_rem_q;
    rem_d     = rem_q;
`endif
    shifted  = {prem_q, quo_q[din0_WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = (shifted >= {1'b0, dvs_q});
    quo_full = qneg_q ? -quo_q : quo_q;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_CALC;
          cnt_d   = CW'(din0_WIDTH);
          // Unsigned negation keeps the most-negative dividend exact as 2^(W-1)
          quo_d   = din0[din0_WIDTH-1] ? -din0 : din0;
          prem_d  = '0;
          dvs_d   = din1[din1_WIDTH-1] ? -din1 : din1;
          qneg_d  = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
          aneg_d  = din0[din0_WIDTH-1];
          zero_d  = (din1 == '0);
        end
      end
      S_CALC: begin
        quo_d  = {quo_q[din0_WIDTH-2:0], fits};
        prem_d = din1_WIDTH'(fits ? diff : shifted);
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (zero_q) begin
          res_quo_d = aneg_q ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
          res_dbz_d = 1'b1;
`ifdef MYPROJECT_SDIV_REM_EN
          res_rem_d = '0;
`endif
        end else begin
          res_quo_d = dout_WIDTH'(quo_full);
          res_dbz_d = 1'b0;
`ifdef MYPROJECT_SDIV_REM_EN
          res_rem_d = aneg_q ? -prem_q : prem_q;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dout_d  = res_quo_q;
        dbz_d   = res_dbz_q;
`ifdef MYPROJECT_SDIV_REM_EN
        rem_d   = res_rem_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      prem_q    <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      aneg_q    <= 1'b0;
      zero_q    <= 1'b0;
      res_quo_q <= '0;
      res_dbz_q <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= '0;
      dbz_q     <= 1'b0;
`ifdef MYPROJECT_SDIV_REM_EN
      res_rem_q <= '0;
      rem_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      prem_q    <= prem_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      aneg_q    <= aneg_d;
      zero_q    <= zero_d;
      res_quo_q <= res_quo_d;
      res_dbz_q <= res_dbz_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
      dbz_q     <= dbz_d;
`ifdef MYPROJECT_SDIV_REM_EN
      res_rem_q <= res_rem_d;
      rem_q     <= rem_d;
`endif
    end
  end

  // Handshake: a request is taken on any rising edge where ap_ready (= ap_idle & ap_start) is high and ap_rst is low.
  assign ap_idle     = (state_q == S_IDLE);
  assign ap_ready    = ap_idle & ap_start;
  assign ap_done     = done_q;
  assign dout        = dout_q;
  assign div_by_zero = dbz_q;
`ifdef MYPROJECT_SDIV_REM_EN
  assign rem         = rem_q;
`endif

endmodule

// File: doc/myproject_sdiv_36s_9s_33_seq.md
MYPROJECT_SDIV_36S_9S_33_SEQ -- requirements
Module: myproject_sdiv_36s_9s_33_seq

Interface
REQ-001 Parameter din0_WIDTH, default 36: dividend width, signed two's complement.
REQ-002 Parameter din1_WIDTH, default 9: divisor width, signed two's complement.
REQ-003 Parameter dout_WIDTH, default 33: quotient width, signed two's complement.
REQ-004 ap_clk  input  1: single clock; all state updates on the rising edge.
REQ-005 ap_rst  input  1: synchronous, active-high reset.
REQ-006 ap_start  input  1: request a division, sampled only in IDLE.
REQ-007 din0  input  din0_WIDTH: dividend, captured in the cycle the request is accepted.
REQ-008 din1  input  din1_WIDTH: divisor, captured in the cycle the request is accepted.
REQ-009 ap_idle  output  1: high while in IDLE.
REQ-010 ap_ready  output  1: combinational, equal to ap_idle AND ap_start (operand acceptance).
REQ-011 ap_done  output  1: registered one-cycle pulse when dout is valid.
REQ-012 dout  output  dout_WIDTH: quotient, registered, held until the next completion.
REQ-013 div_by_zero  output  1: registered, updated with dout, high if the captured divisor was 0.
REQ-014 rem  output  din1_WIDTH: remainder, registered, updated with dout (only present per REQ-031).

Function
REQ-015 FSM states: IDLE, CALC, FIX, DONE.
REQ-016 Transitions: IDLE->CALC on ap_start; CALC->FIX after exactly din0_WIDTH cycles; FIX->DONE; DONE->IDLE unconditionally.
REQ-017 CALC: restoring division on operand magnitudes, one quotient bit per cycle, MSB first, driven by a down-counter of din0_WIDTH iterations.
REQ-018 FIX: applies signs; quotient negated iff operand signs differ; remainder takes the dividend's sign (truncation toward zero).
REQ-019 Latency: ap_done high exactly din0_WIDTH+2 cycles (38 at default) after the accepting edge; throughput is 1 operation per din0_WIDTH+3 cycles.
REQ-020 Most-negative dividend: magnitude formed as a din0_WIDTH-bit unsigned value with no loss.
REQ-021 Quotient width: the full din0_WIDTH-bit signed quotient is truncated to its low dout_WIDTH bits (wrap, no saturation).
REQ-022 Divisor 0: dout = 2^(dout_WIDTH-1)-1 if dividend >= 0, else -2^(dout_WIDTH-1); rem = 0; div_by_zero = 1; latency unchanged.
REQ-023 ap_start outside IDLE (CALC, FIX, DONE) is ignored; ap_ready stays low; no operand recapture.
REQ-024 Input changes on din0/din1 after acceptance do not affect the result in flight.
REQ-025 dout, rem and div_by_zero change only on the cycle ap_done rises.

Reset
REQ-026 ap_rst forces IDLE on the next edge from any state, aborting any operation in flight without an ap_done.
REQ-027 Reset values: ap_done=0, dout=0, rem=0, div_by_zero=0, iteration counter=0; ap_idle=1 after reset.
REQ-028 ap_rst takes priority over ap_start in the same cycle; no request is accepted while ap_rst is high.

Configuration
REQ-029 Macro MYPROJECT_SDIV_REM_EN selects remainder support.
REQ-030 Without MYPROJECT_SDIV_REM_EN: the rem port and its register do not exist; all other behaviour is identical.
REQ-031 With MYPROJECT_SDIV_REM_EN: the rem port exists and behaves per REQ-014, REQ-018, REQ-022, REQ-025 and REQ-027.

Verification
REQ-032 din0=1000, din1=7, ap_start 1 cycle -> ap_done after 38 cycles, dout=142, rem=6, div_by_zero=0.
REQ-033 din0=-1000, din1=7 -> dout=-142, rem=-6; din0=1000, din1=-7 -> dout=-142, rem=6; din0=-1000, din1=-7 -> dout=142, rem=-6.
REQ-034 din0=5, din1=0 -> dout=4294967295, rem=0, div_by_zero=1; din0=-5, din1=0 -> dout=-4294967296.
REQ-035 din0=-2^35, din1=-1 -> dout = low 33 bits of 2^35 = 0; din0=-256, din1=-256 -> dout=1, rem=0.
REQ-036 Pulse ap_start at cycle 10 of a running operation with different operands -> ap_ready stays 0, the first result is unaffected, exactly one ap_done occurs.
REQ-037 Assert ap_rst for 1 cycle at iteration 20 -> no ap_done, ap_idle=1 next cycle, outputs 0; a new request of 100/9 -> dout=11, rem=1 after 38 cycles.
